// File: rtl/axi4_write_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) between one master and the write slave.
// WSTRB is carried only when AXI_WSTRB_EN is defined.
interface axi4_write_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
`ifdef AXI_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] WSTRB;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
`else
  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
`endif
endinterface

// File: rtl/axi4_write_slave.sv
// AXI4 INCR write slave into local memory; one beat/cycle, BVALID 1 cycle after last W beat, W/AW stall on valid=0,
// B held until BREADY. Optional byte strobes with AXI_WSTRB_EN defined.
module axi4_write_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input logic              ACLK,
  input logic              ARESET,
  axi4_write_slave_if.slave axi
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_MAX  = $clog2(BYTES);
  localparam int IDX_W     = $clog2(MEMORY_DEPTH);
  localparam int MEM_BYTES = MEMORY_DEPTH * BYTES;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            beat_q, beat_d;
  logic                  addr_err_q, addr_err_d;
  logic                  last_err_q, last_err_d;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  logic        aw_hs, w_hs, last_beat, aw_err;
  logic [31:0] start_byte, burst_bytes, end_byte;
  logic [IDX_W-1:0] widx;

  assign aw_hs     = axi.AWVALID && awready_q && (state_q == IDLE);
  assign w_hs      = axi.WVALID && wready_q && (state_q == DATA);
  assign last_beat = (beat_q == len_q);

  // Range, 4 KB crossing and oversize checks are all decided once, at address acceptance.
  assign start_byte  = 32'(axi.AWADDR);
  assign burst_bytes = (32'(axi.AWLEN) + 32'd1) << axi.AWSIZE;
  assign end_byte    = start_byte + burst_bytes - 32'd1;
  assign aw_err      = (end_byte >= 32'(MEM_BYTES))
                    || (end_byte[31:12] != start_byte[31:12])
                    || (axi.AWSIZE > 3'(SIZE_MAX));

  assign widx = IDX_W'(addr_q >> SIZE_MAX);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    beat_d     = beat_q;
    addr_err_d = addr_err_q;
    last_err_d = last_err_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          addr_d     = axi.AWADDR;
          len_d      = axi.AWLEN;
          size_d     = axi.AWSIZE;
          beat_d     = 8'd0;
          addr_err_d = aw_err;
          last_err_d = 1'b0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
          beat_d = beat_q + 8'd1;
          if (axi.WLAST != last_beat) last_err_d = 1'b1;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (axi.BREADY && bvalid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered versions of the upcoming state, so they change on the same edge as it.
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
    bresp_d   = ((state_d == RESP) && (addr_err_d || last_err_d)) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      beat_q     <= '0;
      addr_err_q <= 1'b0;
      last_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      beat_q     <= beat_d;
      addr_err_q <= addr_err_d;
      last_err_q <= last_err_d;
    end
  end

  // Storage keeps its contents across reset; a beat presented on a reset edge is dropped.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_hs && !addr_err_q) begin
`ifdef AXI_WSTRB_EN
      for (int b = 0; b < BYTES; b++) begin
        if (axi.WSTRB[b]) mem_q[widx][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
      end
`else
      mem_q[widx] <= axi.WDATA;
`endif
    end
  end

  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = bvalid_q;
  assign axi.BRESP   = bresp_q;
endmodule

// File: tb/tb_axi4_write_slave.sv
// Randomized self-checking bench for axi4_write_slave against a burst-level memory/response model.
module tb_axi4_write_slave;
  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  axi4_write_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi();

  axi4_write_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)) dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .axi   (axi)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Runs one burst end to end; bad_beat (>=0) flips WLAST on that beat.
  task automatic burst(input int addr, input int len, input int size, input int bad_beat,
                       input int bdelay, input bit gaps, input logic [31:0] dbase, input bit rnd);
    logic [31:0] d [$];
    int          nbytes, last_byte, n, idx;
    bit          aerr, lerr;
    logic [1:0]  exp_resp;

    for (int k = 0; k <= len; k++) d.push_back(rnd ? $urandom : dbase + 32'(k));
    nbytes    = (len + 1) << size;
    last_byte = addr + nbytes - 1;
    aerr      = (last_byte >= DEPTH * 4) || ((addr / 4096) != (last_byte / 4096)) || (size > 2);
    lerr      = (bad_beat >= 0);
    exp_resp  = (aerr || lerr) ? 2'b10 : 2'b00;

    axi.AWADDR  = AW'(addr);
    axi.AWLEN   = 8'(len);
    axi.AWSIZE  = 3'(size);
    axi.AWVALID = 1'b1;
    n = 0;
    while (!axi.AWREADY && n < 50) begin tick(); n++; end
    check("awready_wait", axi.AWREADY, 1);
    tick();
    axi.AWVALID = 1'b0;
    check("awready_drop", axi.AWREADY, 0);
    check("wready_up", axi.WREADY, 1);

    for (int k = 0; k <= len; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          axi.WVALID  = 1'b0;
          axi.WDATA   = $urandom;
          axi.AWVALID = 1'($urandom_range(0, 1));
          axi.AWADDR  = AW'($urandom);
          tick();
        end
        axi.AWVALID = 1'b0;
      end
      axi.WVALID = 1'b1;
      axi.WDATA  = d[k];
      axi.WLAST  = (k == len) ^ (k == bad_beat);
      n = 0;
      while (!axi.WREADY && n < 50) begin tick(); n++; end
      check("wready_wait", axi.WREADY, 1);
      tick();
    end
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
    check("bvalid_latency", axi.BVALID, 1);
    check("bresp", axi.BRESP, exp_resp);
    check("wready_drop", axi.WREADY, 0);

    repeat (bdelay) begin
      axi.WVALID = 1'($urandom_range(0, 1));
      axi.WDATA  = $urandom;
      tick();
      check("bvalid_hold", axi.BVALID, 1);
      check("bresp_hold", axi.BRESP, exp_resp);
      check("awready_resp", axi.AWREADY, 0);
    end
    axi.WVALID = 1'b0;
    axi.BREADY = 1'b1;
    tick();
    axi.BREADY = 1'b0;
    check("bvalid_clear", axi.BVALID, 0);
    check("awready_back", axi.AWREADY, 1);

    if (!aerr)
      for (int k = 0; k <= len; k++) exp_mem[(addr + (k << size)) / 4] = d[k];
    for (int k = 0; k <= len; k++) begin
      idx = (addr + (k << size)) / 4;
      if (idx < DEPTH) check("mem", dut.mem_q[idx], exp_mem[idx]);
    end
  endtask

  initial begin
    int a, l, s, bb;
    axi.AWADDR  = '0;
    axi.AWLEN   = '0;
    axi.AWSIZE  = '0;
    axi.AWVALID = 1'b0;
    axi.WDATA   = '0;
    axi.WLAST   = 1'b0;
    axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
`ifdef AXI_WSTRB_EN
    axi.WSTRB   = '1;
`endif
    ARESET = 1'b1;
    repeat (3) tick();
    check("rst_awready", axi.AWREADY, 0);
    check("rst_wready", axi.WREADY, 0);
    check("rst_bvalid", axi.BVALID, 0);
    check("rst_bresp", axi.BRESP, 0);
    ARESET = 1'b0;
    tick();
    check("awready_after_rst", axi.AWREADY, 1);

    for (int base = 0; base < DEPTH * 4; base += 1024) burst(base, 255, 2, -1, 0, 0, 0, 1);

    burst(32'h0010, 3, 2, -1, 0, 1, 32'd1, 0);
    burst(32'h1000, 0, 2, -1, 1, 0, 32'hDEAD0000, 0);
    burst(32'h0FFC, 1, 2, -1, 0, 0, 32'hBEEF0000, 0);
    burst(32'h0100, 2, 2,  1, 2, 0, 32'h00C0FFEE, 0);
    burst(32'h0040, 1, 2, -1, 5, 0, 32'h55AA0000, 0);
    burst(32'h0FF0, 3, 2, -1, 0, 0, 32'h77000000, 0);
    burst(32'h0020, 0, 2, -1, 0, 0, 32'h12345678, 0);

    // Reset after beat 1 of a four-beat burst: beats 0-1 stay written, nothing else happens.
    axi.AWADDR = 16'h0200; axi.AWLEN = 8'd3; axi.AWSIZE = 3'd2; axi.AWVALID = 1'b1;
    tick();
    axi.AWVALID = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi.WVALID = 1'b1;
      axi.WDATA  = 32'hA0 + 32'(k);
      axi.WLAST  = 1'b0;
      tick();
      exp_mem[128 + k] = 32'hA0 + 32'(k);
    end
    axi.WDATA = 32'hBAD0BAD0;
    ARESET    = 1'b1;
    tick();
    ARESET     = 1'b0;
    axi.WVALID = 1'b0;
    check("abort_awready", axi.AWREADY, 0);
    check("abort_wready", axi.WREADY, 0);
    check("abort_bvalid", axi.BVALID, 0);
    check("abort_bresp", axi.BRESP, 0);
    tick();
    check("abort_awready_release", axi.AWREADY, 1);
    repeat (3) begin
      tick();
      check("abort_no_bvalid", axi.BVALID, 0);
    end
    for (int i = 128; i < 132; i++) check("abort_mem", dut.mem_q[i], exp_mem[i]);
    burst(32'h0200, 3, 2, -1, 0, 0, 32'h600D0000, 0);

    repeat (40) begin
      a  = $urandom_range(0, 32'h10FF);
      l  = $urandom_range(0, 15);
      s  = $urandom_range(0, 3);
      bb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
      burst(a, l, s, bb, $urandom_range(0, 4), 1, 0, 1);
    end

    for (int i = 0; i < DEPTH; i++) check("mem_sweep", dut.mem_q[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
